// File: rtl/wshb_frame_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : wshb_frame_reader_if
// Description : SDRAM Wishbone B4 classic bus plus the pixel valid/ready
//               stream leaving the frame reader. The master modport is the
//               frame reader side; the slave modport is the SDRAM/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface wshb_frame_reader_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_ms;
    logic [31:0] wb_dat_sm;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_rty;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_first;
    logic        pix_ready;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_cti, wb_bte, wb_dat_ms,
        input  wb_dat_sm, wb_ack, wb_err, wb_rty,
        output pix_data, pix_valid, pix_first,
        input  pix_ready
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_cti, wb_bte, wb_dat_ms,
        output wb_dat_sm, wb_ack, wb_err, wb_rty,
        input  pix_data, pix_valid, pix_first,
        output pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/wshb_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : wshb_frame_reader
// Description : Wishbone classic master that loops over one framebuffer in
//               SDRAM, reading one 32-bit pixel word per transfer, and hands
//               each word to the video pipeline through a one-deep
//               valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module wshb_frame_reader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 enable,
    input  logic                 frame_restart,
    wshb_frame_reader_if.master  bus,
    output logic                 frame_done,
    output logic                 err_flag
);
    localparam int NPIX = HDISP * VDISP;
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [IW-1:0] c_LAST_IDX = IW'(NPIX - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_REQ  = 1'b1;

    logic [0:0]    r_state;
    logic [IW-1:0] r_idx;
    logic          r_pend;        // restart requested while a transfer was in flight
    logic [31:0]   r_pix_data;
    logic          r_pix_valid;
    logic          r_pix_first;
    logic          r_frame_done;
    logic          r_err_flag;

    logic          w_term_data;
    logic          w_restart;
    logic          w_req_go;
    logic [IW-1:0] w_idx_inc;
    logic [31:0]   w_adr;

    // Ack and err both deliver a word; restart may come now or from earlier.
    assign w_term_data = bus.wb_ack | bus.wb_err;
    assign w_restart   = frame_restart | r_pend;
    // Only start a request when the output register is guaranteed free.
    assign w_req_go    = enable & (~r_pix_valid | bus.pix_ready);
    assign w_idx_inc   = (r_idx == c_LAST_IDX) ? '0 : r_idx + IW'(1);
    assign w_adr       = BASE_ADDR + 32'({r_idx, 2'b00});

    assign bus.wb_cyc    = (r_state == c_ST_REQ);
    assign bus.wb_stb    = (r_state == c_ST_REQ);
    assign bus.wb_we     = 1'b0;
    assign bus.wb_adr    = w_adr;
    assign bus.wb_sel    = 4'hF;
    assign bus.wb_cti    = 3'b000;
    assign bus.wb_bte    = 2'b00;
    assign bus.wb_dat_ms = 32'h0;
    assign bus.pix_data  = r_pix_data;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_first = r_pix_first;
    assign frame_done    = r_frame_done;
    assign err_flag      = r_err_flag;

    // Request sequencing, pixel index, output buffer and status flags.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state      <= c_ST_IDLE;
            r_idx        <= '0;
            r_pend       <= 1'b0;
            r_pix_data   <= 32'h0;
            r_pix_valid  <= 1'b0;
            r_pix_first  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_flag   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_pix_valid && bus.pix_ready) begin
                r_pix_valid <= 1'b0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_restart) begin
                        r_idx  <= '0;
                        r_pend <= 1'b0;
                    end
                    if (w_req_go) begin
                        r_state <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (w_term_data) begin
                        // Err still delivers a (zero) word so the frame stays aligned.
                        r_pix_data  <= bus.wb_ack ? bus.wb_dat_sm : 32'h0;
                        r_pix_valid <= 1'b1;
                        r_pix_first <= (r_idx == '0);
                        if (!bus.wb_ack) begin
                            r_err_flag <= 1'b1;
                        end
                        if (w_restart) begin
                            r_idx <= '0;
                        end else begin
                            r_idx        <= w_idx_inc;
                            r_frame_done <= (r_idx == c_LAST_IDX);
                        end
                        r_pend  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        if (frame_restart) begin
                            r_pend <= 1'b1;
                        end
                        // Retry: drop back and re-request the same index.
                        if (bus.wb_rty) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
